// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: target-side data-memory responder for the vscale dmem port.
// Accepts an address phase (en/wen/size/addr), completes the data phase one or more
// cycles later, with byte-lane write masking, WAIT_CYCLES wait states and bad-access
// reporting. Write data arrives one cycle after its address (dmem_wdata_delayed).
// Optional feature macro: DMEM_RESP_ZERO_INIT_EN -- when defined, the array is swept to
// zero (one word per cycle) after every reset release; data phases wait for the sweep.

`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif

module vscale_dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [`XPR_LEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dmem_en,
  input  logic                       dmem_wen,
  input  logic [`MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [`XPR_LEN-1:0]        dmem_addr,
  input  logic [`XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [`XPR_LEN-1:0]        dmem_rdata,
  output logic                       dmem_wait,
  output logic                       dmem_badmem_e
);

  localparam int XLEN  = `XPR_LEN;
  localparam int MTW   = `MEM_TYPE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [MTW-1:0] SIZE_BYTE = MTW'(0);
  localparam logic [MTW-1:0] SIZE_HALF = MTW'(1);
  localparam logic [MTW-1:0] SIZE_WORD = MTW'(2);

  // Byte span of the array; one bit wider than the address so BASE+span cannot overflow.
  localparam logic [XLEN:0] MEM_SPAN = {{XLEN{1'b0}}, 1'b1} << (ADDR_WIDTH + 2);
  localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  // Lane write-enable for a store of the given size starting at the given byte lane.
  function automatic logic [3:0] store_mask(input logic [MTW-1:0] size,
                                            input logic [1:0]     lane);
    case (size)
      SIZE_BYTE: store_mask = 4'b0001 << lane;
      SIZE_HALF: store_mask = 4'b0011 << lane;
      SIZE_WORD: store_mask = 4'b1111;
      default:   store_mask = 4'b0000;
    endcase
  endfunction

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic                    p_wen_r;
  logic [MTW-1:0]          p_size_r;
  logic [ADDR_WIDTH-1:0]   p_word_r;
  logic [1:0]              p_lane_r;
  logic                    p_bad_r;

  logic [XLEN:0]           offset_s;
  logic                    below_base_s;
  logic                    out_of_range_s;
  logic                    size_bad_s;
  logic                    misalign_s;
  logic                    bad_s;
  logic                    accept_s;
  logic                    sweep_hold_s;
  logic                    commit_s;

  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_idx_s;
  logic [3:0]              wr_mask_s;
  logic [XLEN-1:0]         wr_data_s;

  logic [XLEN-1:0]         mem [DEPTH];

  // Offset from the array base; BASE_ADDR is word aligned so offset[1:0] equals addr[1:0].
  assign offset_s       = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
  assign below_base_s   = (dmem_addr < BASE_ADDR);
  assign out_of_range_s = below_base_s || (offset_s >= MEM_SPAN);

  // Classify the presented address phase: illegal size or misaligned access.
  always_comb begin
    size_bad_s = 1'b0;
    misalign_s = 1'b0;
    case (dmem_size)
      SIZE_BYTE: misalign_s = 1'b0;
      SIZE_HALF: misalign_s = offset_s[0];
      SIZE_WORD: misalign_s = |offset_s[1:0];
      default:   size_bad_s = 1'b1;
    endcase
  end

  assign bad_s    = size_bad_s || misalign_s || out_of_range_s;
  assign accept_s = dmem_en && !dmem_wait;

`ifdef DMEM_RESP_ZERO_INIT_EN
  logic                  sweep_busy_r;
  logic [ADDR_WIDTH-1:0] sweep_idx_r;

  // Zero-fill sweep: restarts at index 0 whenever reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_busy_r <= 1'b1;
      sweep_idx_r  <= {ADDR_WIDTH{1'b0}};
    end else if (sweep_busy_r) begin
      sweep_idx_r <= sweep_idx_r + ADDR_WIDTH'(1);
      if (sweep_idx_r == {ADDR_WIDTH{1'b1}}) begin
        sweep_busy_r <= 1'b0;
      end
    end
  end

  assign sweep_hold_s = sweep_busy_r;
`else
  assign sweep_hold_s = 1'b0;
`endif

  // A data phase stalls while wait states remain or the zero-fill sweep is still running.
  assign dmem_wait     = (state_r == ST_DATA) && ((cnt_r != 4'd0) || sweep_hold_s);
  assign dmem_badmem_e = (state_r == ST_DATA) && p_bad_r;
  assign commit_s      = (state_r == ST_DATA) && !dmem_wait && p_wen_r && !p_bad_r;

  // Request FSM: captures accepted address phases and counts down wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      p_wen_r  <= 1'b0;
      p_size_r <= SIZE_BYTE;
      p_word_r <= {ADDR_WIDTH{1'b0}};
      p_lane_r <= 2'd0;
      p_bad_r  <= 1'b0;
    end else if (accept_s) begin
      state_r  <= ST_DATA;
      cnt_r    <= bad_s ? 4'd0 : WAIT_LOAD;
      p_wen_r  <= dmem_wen;
      p_size_r <= dmem_size;
      p_word_r <= offset_s[ADDR_WIDTH+1:2];
      p_lane_r <= offset_s[1:0];
      p_bad_r  <= bad_s;
    end else if (state_r == ST_DATA) begin
      if (!dmem_wait) begin
        state_r <= ST_IDLE;
      end else if (!sweep_hold_s && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      state_r <= state_r;
    end
  end

  // Select the single array write port user: zero-fill sweep or a committing store.
  always_comb begin
    wr_en_s   = commit_s;
    wr_idx_s  = p_word_r;
    wr_mask_s = store_mask(p_size_r, p_lane_r);
    wr_data_s = dmem_wdata_delayed;
`ifdef DMEM_RESP_ZERO_INIT_EN
    if (sweep_busy_r) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = sweep_idx_r;
      wr_mask_s = 4'b1111;
      wr_data_s = {XLEN{1'b0}};
    end else begin
      wr_en_s   = commit_s;
    end
`endif
  end

  // Array write with per-byte-lane enables; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_s[b]) begin
          mem[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Load data: the whole aligned word during a good load data phase, zero otherwise.
  always_comb begin
    if ((state_r == ST_DATA) && !p_wen_r && !p_bad_r) begin
      dmem_rdata = mem[p_word_r];
    end else begin
      dmem_rdata = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed self-checking bench for vscale_dmem_responder (default build).
// Three instances share the request inputs: u0 (no wait states), u2 (two wait states)
// and u3 (three wait states, array based at 0x1000); each scenario checks one of them.

module tb_vscale_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wen;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata0, rdata2, rdata3;
  logic        wait0, wait2, wait3;
  logic        bad0, bad2, bad3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vscale_dmem_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .dmem_en(en), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata_delayed(wdata),
    .dmem_rdata(rdata0), .dmem_wait(wait0), .dmem_badmem_e(bad0));

  vscale_dmem_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .dmem_en(en), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata_delayed(wdata),
    .dmem_rdata(rdata2), .dmem_wait(wait2), .dmem_badmem_e(bad2));

  vscale_dmem_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .dmem_en(en), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata_delayed(wdata),
    .dmem_rdata(rdata3), .dmem_wait(wait3), .dmem_badmem_e(bad3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; size = s; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    #2;
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL reset_wait0: got %b want 0", wait0); end
    checks++; if (bad0 !== 1'b0) begin errors++; $display("FAIL reset_bad0: got %b want 0", bad0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    checks++; if (wait2 !== 1'b0) begin errors++; $display("FAIL reset_wait2: got %b want 0", wait2); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", rdata2); end
    checks++; if (wait3 !== 1'b0) begin errors++; $display("FAIL reset_wait3: got %b want 0", wait3); end
    checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL reset_bad3: got %b want 0", bad3); end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_store_load();
    drive(1'b1, 1'b1, 3'd2, 32'h10, 32'h0);
    step();
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL w0_store_wait: got %b want 0", wait0); end
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    step();
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL w0_load_wait: got %b want 0", wait0); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL w0_load_data: got %h want deadbeef", rdata0); end
    idle(1);
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL w0_idle_rdata: got %h want 0", rdata0); end
  endtask

  task automatic test_byte_half();
    drive(1'b1, 1'b1, 3'd2, 32'h10, 32'h0);
    step();
    drive(1'b1, 1'b1, 3'd0, 32'h13, 32'h11223344);
    step();
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h5A5A5A5A);
    step();
    checks++; if (rdata0 !== 32'h5A223344) begin errors++; $display("FAIL byte_merge: got %h want 5a223344", rdata0); end
    drive(1'b1, 1'b1, 3'd1, 32'h12, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'd0, 32'h11, 32'hABCDABCD);
    step();
    checks++; if (rdata0 !== 32'hABCD3344) begin errors++; $display("FAIL half_merge: got %h want abcd3344", rdata0); end
    checks++; if (bad0 !== 1'b0) begin errors++; $display("FAIL byte_load_bad: got %b want 0", bad0); end
    idle(1);
  endtask

  task automatic test_bad_access();
    drive(1'b1, 1'b1, 3'd2, 32'h20, 32'h0);
    step();
    drive(1'b1, 1'b1, 3'd2, 32'h22, 32'hCAFEF00D);
    step();
    checks++; if (bad0 !== 1'b1) begin errors++; $display("FAIL misalign_bad: got %b want 1", bad0); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL misalign_wait: got %b want 0", wait0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rdata0); end
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h11111111);
    step();
    checks++; if (bad0 !== 1'b1) begin errors++; $display("FAIL range_bad: got %b want 1", bad0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL range_rdata: got %h want 0", rdata0); end
    drive(1'b1, 1'b1, 3'd3, 32'h20, 32'h22222222);
    step();
    checks++; if (bad0 !== 1'b1) begin errors++; $display("FAIL size3_bad: got %b want 1", bad0); end
    checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL size3_wait: got %b want 0", wait0); end
    drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h33333333);
    step();
    checks++; if (bad0 !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b want 0", bad0); end
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL bad_no_write: got %h want cafef00d", rdata0); end
    drive(1'b1, 1'b0, 3'd1, 32'h21, 32'h0);
    step();
    checks++; if (bad0 !== 1'b1) begin errors++; $display("FAIL half_odd_bad: got %b want 1", bad0); end
    idle(1);
    checks++; if (bad0 !== 1'b0) begin errors++; $display("FAIL bad_one_cycle: got %b want 0", bad0); end
  endtask

  task automatic test_wait_states();
    int n;
    idle(5);
    drive(1'b1, 1'b1, 3'd2, 32'h20, 32'h0);
    step();
    drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h0BADF00D);
    n = 0;
    for (int i = 0; i < 10 && wait2 === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 2) begin errors++; $display("FAIL ws_store_len: got %0d want 2", n); end
    step();
    n = 0;
    for (int i = 0; i < 10 && wait2 === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 2) begin errors++; $display("FAIL ws_load_len: got %0d want 2", n); end
    checks++; if (rdata2 !== 32'h0BADF00D) begin errors++; $display("FAIL ws_load_data: got %h want 0badf00d", rdata2); end
    step();
    checks++; if (wait2 !== 1'b1) begin errors++; $display("FAIL ws_accept_edge: got %b want 1", wait2); end
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 10 && wait2 === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 2) begin errors++; $display("FAIL ws_repeat_len: got %0d want 2", n); end
    checks++; if (rdata2 !== 32'h0BADF00D) begin errors++; $display("FAIL ws_repeat_data: got %h want 0badf00d", rdata2); end
    step();
    checks++; if (wait2 !== 1'b0) begin errors++; $display("FAIL ws_idle_wait: got %b want 0", wait2); end
    drive(1'b1, 1'b0, 3'd2, 32'h21, 32'h0);
    step();
    checks++; if (wait2 !== 1'b0) begin errors++; $display("FAIL ws_bad_nowait: got %b want 0", wait2); end
    checks++; if (bad2 !== 1'b1) begin errors++; $display("FAIL ws_bad_flag: got %b want 1", bad2); end
    idle(1);
  endtask

  task automatic test_reset_mid_wait();
    int n;
    idle(5);
    drive(1'b1, 1'b1, 3'd2, 32'h1030, 32'h0);
    step();
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h00001234);
    n = 0;
    for (int i = 0; i < 10 && wait3 === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 3) begin errors++; $display("FAIL rst_old_len: got %0d want 3", n); end
    step();
    drive(1'b1, 1'b1, 3'd2, 32'h1030, 32'h0);
    step();
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
    step();
    checks++; if (wait3 !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: got %b want 1", wait3); end
    #2 reset = 1'b1;
    #1;
    checks++; if (wait3 !== 1'b0) begin errors++; $display("FAIL rst_async_wait: got %b want 0", wait3); end
    checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL rst_async_bad: got %b want 0", bad3); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rst_async_rdata: got %h want 0", rdata3); end
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd2, 32'h1030, 32'h0);
    step();
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 10 && wait3 === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 3) begin errors++; $display("FAIL rst_load_len: got %0d want 3", n); end
    checks++; if (rdata3 !== 32'h00001234) begin errors++; $display("FAIL rst_store_dropped: got %h want 00001234", rdata3); end
    step();
    drive(1'b1, 1'b0, 3'd2, 32'h0FFC, 32'h0);
    step();
    checks++; if (bad3 !== 1'b1) begin errors++; $display("FAIL below_base_bad: got %b want 1", bad3); end
    checks++; if (wait3 !== 1'b0) begin errors++; $display("FAIL below_base_wait: got %b want 0", wait3); end
    drive(1'b1, 1'b0, 3'd2, 32'h1100, 32'h0);
    step();
    checks++; if (bad3 !== 1'b1) begin errors++; $display("FAIL above_top_bad: got %b want 1", bad3); end
    drive(1'b1, 1'b0, 3'd2, 32'h10FC, 32'h0);
    step();
    checks++; if (bad3 !== 1'b0) begin errors++; $display("FAIL top_word_good: got %b want 0", bad3); end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_half();
    test_bad_access();
    test_wait_states();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
